fetch_queue: RTL and testbench

- Parametrised successor to the single-register fetch stage. Generates sequential or predicted PCs and issues one I-memory request per cycle.
- Each returned instruction is pushed, together with its PC and prediction bit, into a DEPTH-entry FIFO. Decode drains the FIFO with a valid/ready handshake.
- Decouples I-cache hit timing from decode stalls. Misprediction redirects flush all queued and in-flight work.

---
 rtl/fetch_queue.sv | 120 ++++++++++++
 tb/tb_fetch_queue.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Fetch stage with a DEPTH-entry instruction queue between I-memory and decode.
// Redirects from execute flush the queue and the pending fetch in one cycle.
module fetch_queue #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000,
  parameter int unsigned DEPTH   = 4,
  parameter logic [31:0] PC_STEP = 32'h0000_0004
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       ihit,
  input  logic [31:0]                imemload,
  output logic                       imemREN,
  output logic [31:0]                imemaddr,
  output logic [31:0]                fetch_pc,
  input  logic                       pred_taken,
  input  logic [31:0]                pred_target,
  input  logic                       misprediction,
  input  logic [31:0]                correct_pc,
  input  logic                       deq_ready,
  output logic                       deq_valid,
  output logic [31:0]                deq_instr,
  output logic [31:0]                deq_pc,
  output logic                       deq_pred,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pred;
  } entry_t;

  entry_t        storage_r [DEPTH];
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;
  logic [31:0]   fetch_pc_r;

  logic          full_s;
  logic          empty_s;
  logic          ren_s;
  logic          push_s;
  logic          pop_s;
  logic [31:0]   next_pc_s;
  entry_t        head_s;

  // Handshake decode, next-PC selection and head read-out
  always_comb begin
    full_s    = (count_r == FULL_CNT);
    empty_s   = (count_r == CNT_ZERO);
    ren_s     = !full_s && !misprediction;
    push_s    = ihit && ren_s;
    pop_s     = !empty_s && deq_ready && !misprediction;
    head_s    = storage_r[rd_ptr_r];
    if (pred_taken) begin
      next_pc_s = pred_target;
    end else begin
      next_pc_s = fetch_pc_r + PC_STEP;
    end
    // Head fields are forced to zero while empty so stale storage never shows.
    if (empty_s) begin
      deq_instr = 32'h0000_0000;
      deq_pc    = 32'h0000_0000;
      deq_pred  = 1'b0;
    end else begin
      deq_instr = head_s.instr;
      deq_pc    = head_s.pc;
      deq_pred  = head_s.pred;
    end
    imemREN   = ren_s;
    imemaddr  = fetch_pc_r;
    fetch_pc  = fetch_pc_r;
    deq_valid = !empty_s;
    count     = count_r;
  end

  // Fetch PC, queue pointers and occupancy; redirect outranks push and pop
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      fetch_pc_r <= PC_INIT;
      rd_ptr_r   <= PTR_ZERO;
      wr_ptr_r   <= PTR_ZERO;
      count_r    <= CNT_ZERO;
    end else if (misprediction) begin
      fetch_pc_r <= correct_pc;
      rd_ptr_r   <= PTR_ZERO;
      wr_ptr_r   <= PTR_ZERO;
      count_r    <= CNT_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_r   <= wr_ptr_r + PTR_ONE;
        fetch_pc_r <= next_pc_s;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents need no reset because count gates visibility
  always_ff @(posedge CLK) begin
    if (push_s) begin
      storage_r[wr_ptr_r] <= '{pc: fetch_pc_r, instr: imemload, pred: pred_taken};
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomised and directed bench for fetch_queue against a queue-based reference model.
module tb_fetch_queue;

  localparam int          DEPTH   = 4;
  localparam logic [31:0] PC_INIT = 32'h0000_0000;
  localparam int          CW      = $clog2(DEPTH + 1);

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic          ihit = 1'b0;
  logic          pred_taken = 1'b0;
  logic          misprediction = 1'b0;
  logic          deq_ready = 1'b0;
  logic [31:0]   pred_target = 32'h0;
  logic [31:0]   correct_pc = 32'h0;
  logic [31:0]   load_salt = 32'h1234_5678;
  logic [31:0]   imemload;
  logic          imemREN;
  logic [31:0]   imemaddr;
  logic [31:0]   fetch_pc;
  logic          deq_valid;
  logic [31:0]   deq_instr;
  logic [31:0]   deq_pc;
  logic          deq_pred;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pred;
  } ent_t;

  ent_t        mq[$];
  ent_t        m_ent;
  logic [31:0] m_pc = 32'h0;
  bit          m_known = 1'b0;
  bit          m_after_reset = 1'b0;
  bit          do_push;
  bit          do_pop;

  // I-memory stand-in: word depends on the address so misrouted entries show up
  assign imemload = imemaddr ^ load_salt;

  always #5 CLK = ~CLK;

  fetch_queue #(.PC_INIT(PC_INIT), .DEPTH(DEPTH), .PC_STEP(32'h0000_0004)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload),
    .imemREN(imemREN), .imemaddr(imemaddr), .fetch_pc(fetch_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .misprediction(misprediction), .correct_pc(correct_pc),
    .deq_ready(deq_ready), .deq_valid(deq_valid), .deq_instr(deq_instr),
    .deq_pc(deq_pc), .deq_pred(deq_pred), .count(count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare against the model, then advance it with the inputs the next edge will see
  always @(negedge CLK) begin
    if (m_known) begin
      check("imemaddr", imemaddr, m_pc);
      check("fetch_pc", fetch_pc, m_pc);
      check("imemREN", imemREN, (mq.size() != DEPTH) && !misprediction);
      check("count", count, 32'(mq.size()));
      check("deq_valid", deq_valid, mq.size() != 0);
      if (mq.size() != 0) begin
        check("deq_pc", deq_pc, mq[0].pc);
        check("deq_instr", deq_instr, mq[0].instr);
        check("deq_pred", deq_pred, mq[0].pred);
      end
      if (m_after_reset) begin
        check("rst_deq_pc", deq_pc, 32'h0);
        check("rst_deq_instr", deq_instr, 32'h0);
        check("rst_deq_pred", deq_pred, 32'h0);
      end
    end
    m_after_reset = 1'b0;
    if (!nRST) begin
      m_pc = PC_INIT;
      mq.delete();
      m_known = 1'b1;
      m_after_reset = 1'b1;
    end else if (misprediction) begin
      m_pc = correct_pc;
      mq.delete();
    end else begin
      do_push = ihit && (mq.size() != DEPTH);
      do_pop  = deq_ready && (mq.size() != 0);
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        m_ent.pc = m_pc;
        m_ent.instr = imemload;
        m_ent.pred = pred_taken;
        mq.push_back(m_ent);
        m_pc = pred_taken ? pred_target : m_pc + 32'h4;
      end
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    nRST = 1'b0; ihit = 1'b0; deq_ready = 1'b0;
    misprediction = 1'b0; pred_taken = 1'b0;
    cyc();
    nRST = 1'b1;
  endtask

  initial begin
    repeat (2) cyc();
    check("rst_count", count, 32'h0);
    check("rst_valid", deq_valid, 32'h0);
    check("rst_addr", imemaddr, 32'h0);

    // Sequential fetch straight out of reset
    nRST = 1'b1; ihit = 1'b1; deq_ready = 1'b1;
    check("t1_addr0", imemaddr, 32'h0);
    cyc();
    check("t1_addr4", imemaddr, 32'h4);
    check("t1_pc0", deq_pc, 32'h0);
    check("t1_ins0", deq_instr, 32'h1234_5678);
    cyc();
    check("t1_addr8", imemaddr, 32'h8);
    check("t1_pc4", deq_pc, 32'h4);
    check("t1_ins4", deq_instr, 32'h1234_567C);
    cyc();
    check("t1_pc8", deq_pc, 32'h8);
    check("t1_ins8", deq_instr, 32'h1234_5670);

    // Fill to full, then one pop
    do_reset();
    ihit = 1'b1;
    repeat (6) cyc();
    check("t2_count_full", count, 32'd4);
    check("t2_ren_low", imemREN, 32'h0);
    check("t2_pc_hold", imemaddr, 32'h10);
    deq_ready = 1'b1;
    cyc();
    deq_ready = 1'b0;
    check("t2_count3", count, 32'd3);
    check("t2_head", deq_pc, 32'h4);
    check("t2_ren_high", imemREN, 32'h1);
    cyc();
    check("t2_count4", count, 32'd4);
    check("t2_addr14", imemaddr, 32'h14);

    // Predicted-taken branch at 0x8
    do_reset();
    ihit = 1'b1; deq_ready = 1'b1;
    repeat (2) cyc();
    pred_taken = 1'b1; pred_target = 32'h100;
    cyc();
    pred_taken = 1'b0;
    check("t3_addr_tgt", imemaddr, 32'h100);
    check("t3_pc8", deq_pc, 32'h8);
    check("t3_pred1", deq_pred, 32'h1);
    cyc();
    check("t3_pc_tgt", deq_pc, 32'h100);
    check("t3_pred0", deq_pred, 32'h0);

    // Redirect with push and pop requested in the same cycle
    do_reset();
    ihit = 1'b1;
    repeat (3) cyc();
    check("t4_count3", count, 32'd3);
    misprediction = 1'b1; correct_pc = 32'h40; deq_ready = 1'b1;
    #1;
    check("t4_ren_gated", imemREN, 32'h0);
    cyc();
    check("t4_count0", count, 32'h0);
    check("t4_valid0", deq_valid, 32'h0);
    check("t4_addr40", imemaddr, 32'h40);
    misprediction = 1'b0;
    cyc();
    check("t4_pc40", deq_pc, 32'h40);
    misprediction = 1'b1; correct_pc = 32'h80;
    cyc();
    correct_pc = 32'h90;
    cyc();
    misprediction = 1'b0;
    check("t4_b2b_addr", imemaddr, 32'h90);
    check("t4_b2b_count", count, 32'h0);

    // Simultaneous push and pop across pointer wrap
    do_reset();
    ihit = 1'b1;
    repeat (2) cyc();
    deq_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("t5_count", count, 32'd2);
      check("t5_pc", deq_pc, 32'(4 * (i + 1)));
    end

    // Reset mid-run
    do_reset();
    ihit = 1'b1;
    repeat (3) cyc();
    check("t6_count3", count, 32'd3);
    nRST = 1'b0;
    cyc();
    nRST = 1'b1; ihit = 1'b0;
    check("t6_count0", count, 32'h0);
    check("t6_valid0", deq_valid, 32'h0);
    check("t6_addr", imemaddr, PC_INIT);

    // Random traffic checked by the model
    for (int i = 0; i < 3000; i++) begin
      nRST          = ($urandom_range(0, 199) != 0);
      ihit          = ($urandom_range(0, 9) < 7);
      deq_ready     = ($urandom_range(0, 9) < 6);
      pred_taken    = ($urandom_range(0, 9) == 0);
      pred_target   = $urandom() & 32'hFFFF_FFFC;
      misprediction = ($urandom_range(0, 29) == 0);
      correct_pc    = $urandom() & 32'hFFFF_FFFC;
      load_salt     = $urandom();
      cyc();
    end

    do_reset();
    cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
